i2c_target_regfile: RTL and testbench

Clocked I2C target with a parametrised 7-bit address and register window, supporting writes and reads with pointer auto-increment. It is the next generation of the I2C slave in the TinyTapeout top. It samples SCL/SDA on the system clock instead of using them as clocks, and drives SDA open-drain for both ACK and read data. It sits between the uio pads (SDA = uio[0], SCL = uio[1]) and the core's register bus.

---
 rtl/i2c_target_pkg.sv | 25 ++
 rtl/i2c_line_filter.sv | 52 +++++
 rtl/i2c_target_regfile.sv | 246 ++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the clocked I2C register-file target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  localparam int   I2C_BYTE_BITS = 8;
  localparam logic RW_READ       = 1'b1;

  // Sub-phases of an acknowledge slot.
  localparam logic [1:0] PH_DRIVE  = 2'd0;
  localparam logic [1:0] PH_SAMPLE = 2'd1;
  localparam logic [1:0] PH_RELOAD = 2'd2;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus run-length filter for one I2C line, with one-clk edge pulses.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic          filt_r;
  logic          rise_r;
  logic          fall_r;

  // Filtered level flips only after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b11;
      cnt_r  <= '0;
      filt_r <= 1'b1;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], raw};
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (sync_r[1] != filt_r) begin
        if (cnt_r == CW'(FILT_LEN - 1)) begin
          filt_r <= sync_r[1];
          cnt_r  <= '0;
          rise_r <= sync_r[1];
          fall_r <= ~sync_r[1];
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign filt = filt_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/i2c_target_regfile.sv
// Clocked I2C target exposing a register window with auto-incrementing pointer.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int          NUM_REGS    = 11,
  parameter int          FILT_LEN    = 3,
  localparam int         PW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          wr_en,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [PW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          busy
);

  localparam logic [2:0] LAST_BIT = 3'(I2C_BYTE_BITS - 1);

  logic scl_filt_s, scl_rise_s, scl_fall_s;
  logic sda_filt_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s, last_bit_s;
  logic [I2C_BYTE_BITS-1:0] byte_s;

  state_t                   state_r;
  logic [2:0]               bit_cnt_r;
  logic [I2C_BYTE_BITS-1:0] shift_r;
  logic [PW-1:0]            ptr_r;
  logic [1:0]               phase_r;
  logic                     rw_r;
  logic                     sda_oe_r;
  logic                     wr_en_r;
  logic [PW-1:0]            wr_addr_r;
  logic [7:0]               wr_data_r;
  logic                     busy_r;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (scl_in),
    .filt (scl_filt_s),
    .rise (scl_rise_s),
    .fall (scl_fall_s)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (sda_in),
    .filt (sda_filt_s),
    .rise (sda_rise_s),
    .fall (sda_fall_s)
  );

  assign start_s    = sda_fall_s & scl_filt_s;
  assign stop_s     = sda_rise_s & scl_filt_s;
  assign byte_s     = {shift_r[I2C_BYTE_BITS-2:0], sda_filt_s};
  assign last_bit_s = (bit_cnt_r == LAST_BIT);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(NUM_REGS - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Protocol FSM: bits sampled on SCL rise, SDA drive changed only on SCL fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= '0;
      ptr_r     <= '0;
      phase_r   <= PH_DRIVE;
      rw_r      <= 1'b0;
      sda_oe_r  <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= 8'h00;
      busy_r    <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      if (wr_en_r) begin
        ptr_r <= ptr_inc(ptr_r);
      end
      if (start_s) begin
        state_r   <= ADDR;
        bit_cnt_r <= 3'd0;
        phase_r   <= PH_DRIVE;
        sda_oe_r  <= 1'b0;
      end else if (stop_s) begin
        state_r  <= IDLE;
        phase_r  <= PH_DRIVE;
        sda_oe_r <= 1'b0;
        busy_r   <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            sda_oe_r <= 1'b0;
          end
          ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (last_bit_s) begin
                // Address 0 is the general call and is never claimed.
                if ((byte_s[7:1] == TARGET_ADDR) && (byte_s[7:1] != 7'd0)) begin
                  state_r <= ADDR_ACK;
                  busy_r  <= 1'b1;
                  rw_r    <= byte_s[0];
                end else begin
                  state_r <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall_s) begin
              if (phase_r == PH_DRIVE) begin
                sda_oe_r <= 1'b1;
                phase_r  <= PH_SAMPLE;
              end else begin
                phase_r   <= PH_DRIVE;
                bit_cnt_r <= 3'd0;
                if (rw_r == RW_READ) begin
                  shift_r  <= rd_data;
                  sda_oe_r <= ~rd_data[7];
                  state_r  <= RDATA;
                end else begin
                  sda_oe_r <= 1'b0;
                  state_r  <= PTR;
                end
              end
            end
          end
          PTR: begin
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (last_bit_s) begin
                if ({1'b0, byte_s} < 9'(NUM_REGS)) begin
                  ptr_r   <= byte_s[PW-1:0];
                  state_r <= PTR_ACK;
                end else begin
                  state_r <= WAIT_STOP;
                end
              end
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall_s) begin
              if (phase_r == PH_DRIVE) begin
                sda_oe_r <= 1'b1;
                phase_r  <= PH_SAMPLE;
              end else begin
                sda_oe_r  <= 1'b0;
                phase_r   <= PH_DRIVE;
                bit_cnt_r <= 3'd0;
                state_r   <= WDATA;
              end
            end
          end
          WDATA: begin
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (last_bit_s) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= ptr_r;
                wr_data_r <= byte_s;
                state_r   <= WDATA_ACK;
              end
            end
          end
          RDATA: begin
            if (scl_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (last_bit_s) begin
                phase_r <= PH_DRIVE;
                state_r <= RDATA_ACK;
              end
            end else if (scl_fall_s) begin
              shift_r  <= {shift_r[I2C_BYTE_BITS-2:0], shift_r[I2C_BYTE_BITS-1]};
              sda_oe_r <= ~shift_r[I2C_BYTE_BITS-2];
            end
          end
          RDATA_ACK: begin
            case (phase_r)
              PH_DRIVE: begin
                if (scl_fall_s) begin
                  sda_oe_r <= 1'b0;
                  phase_r  <= PH_SAMPLE;
                end
              end
              PH_SAMPLE: begin
                if (scl_rise_s) begin
                  if (sda_filt_s) begin
                    phase_r <= PH_DRIVE;
                    state_r <= WAIT_STOP;
                  end else begin
                    // Advance now so rd_data has settled by the reload fall.
                    ptr_r   <= ptr_inc(ptr_r);
                    phase_r <= PH_RELOAD;
                  end
                end
              end
              PH_RELOAD: begin
                if (scl_fall_s) begin
                  shift_r   <= rd_data;
                  sda_oe_r  <= ~rd_data[7];
                  bit_cnt_r <= 3'd0;
                  phase_r   <= PH_DRIVE;
                  state_r   <= RDATA;
                end
              end
              default: begin
                phase_r <= PH_DRIVE;
              end
            endcase
          end
          WAIT_STOP: begin
            sda_oe_r <= 1'b0;
          end
          default: begin
            state_r  <= IDLE;
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe  = sda_oe_r;
  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign rd_addr = ptr_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, core register model, write scoreboard.
module tb_i2c_target_regfile;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, wr_en, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic [7:0] regs [0:15];

  assign scl_in  = scl_m;
  assign sda_in  = sda_m & ~sda_oe;
  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  i2c_target_regfile #(.TARGET_ADDR(7'h2A), .NUM_REGS(11), .FILT_LEN(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack_addr;
    logic       ack_ptr;
    logic [3:0] fin_ptr;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[5];
  int   n_vec = 0;
  int   n_miss = 0;
  int   oe_cnt = 0;
  logic prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wclk(Q); sda_m = 1'b1;
    wclk(Q); scl_m = 1'b1;
    wclk(2*Q); sda_m = 1'b0;
    wclk(2*Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(Q); sda_m = 1'b0;
    wclk(Q); scl_m = 1'b1;
    wclk(2*Q); sda_m = 1'b1;
    wclk(2*Q);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    wclk(Q); sda_m = b;
    if (glitch) begin
      wclk(2); scl_m = 1'b1;
      wclk(2); scl_m = 1'b0;
      wclk(Q-4);
    end else begin
      wclk(Q);
    end
    scl_m = 1'b1;
    wclk(2*Q); scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wclk(Q); sda_m = 1'b1;
    wclk(Q); scl_m = 1'b1;
    wclk(Q); b = sda_in;
    wclk(Q); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] v, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(mack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    logic [3:0] mptr;
    logic [7:0] dv;
    int         oe0;

    vecs[0] = '{8'h54, 8'h03, 8'hA5, 8'h5A, 1'b1, 1'b1, 4'd5};
    vecs[1] = '{8'h54, 8'h0A, 8'h11, 8'h22, 1'b1, 1'b1, 4'd1};
    vecs[2] = '{8'hA0, 8'h01, 8'h99, 8'h98, 1'b0, 1'b0, 4'd1};
    vecs[3] = '{8'h54, 8'h0B, 8'h77, 8'h78, 1'b1, 1'b0, 4'd1};
    vecs[4] = '{8'h00, 8'h02, 8'h66, 8'h67, 1'b0, 1'b0, 4'd1};
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;

    fork
      forever begin
        @(negedge clk);
        if (sda_oe) oe_cnt++;
        if (wr_en) begin
          chk("wr_en single clk", {31'd0, prev_wr}, 32'd0);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected write: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
            chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
          end
          regs[wr_addr] = wr_data;
        end
        prev_wr = wr_en;
      end
    join_none

    wclk(4);
    rst = 1'b0;
    wclk(4);
    chk("reset sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("reset wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("reset wr_data", {24'd0, wr_data}, 32'd0);
    chk("reset rd_addr", {28'd0, rd_addr}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);

    mptr = 4'd0;
    for (int v = 0; v < 5; v++) begin
      oe0 = oe_cnt;
      i2c_start();
      write_byte(vecs[v].addr_byte, -1, ack);
      chk("addr ack", {31'd0, ~ack}, {31'd0, vecs[v].ack_addr});
      chk("busy after addr", {31'd0, busy}, {31'd0, vecs[v].ack_addr});
      write_byte(vecs[v].ptr, -1, ack);
      chk("ptr ack", {31'd0, ~ack}, {31'd0, vecs[v].ack_ptr});
      if (vecs[v].ack_ptr) mptr = vecs[v].ptr[3:0];
      for (int d = 0; d < 2; d++) begin
        dv = (d == 0) ? vecs[v].d0 : vecs[v].d1;
        if (vecs[v].ack_ptr) begin
          exp_q.push_back('{mptr, dv});
          mptr = (mptr == 4'd10) ? 4'd0 : mptr + 4'd1;
        end
        write_byte(dv, -1, ack);
        chk("data ack", {31'd0, ~ack}, {31'd0, vecs[v].ack_ptr});
      end
      i2c_stop();
      wclk(Q);
      chk("busy after stop", {31'd0, busy}, 32'd0);
      chk("final pointer", {28'd0, rd_addr}, {28'd0, vecs[v].fin_ptr});
      chk("sda_oe activity", {31'd0, oe_cnt != oe0}, {31'd0, vecs[v].ack_addr});
    end

    // Write pointer 2, repeated START, read two bytes.
    regs[2] = 8'hC3;
    regs[3] = 8'h3C;
    i2c_start();
    write_byte(8'h54, -1, ack);
    chk("rd addr(W) ack", {31'd0, ack}, 32'd0);
    write_byte(8'h02, -1, ack);
    chk("rd ptr ack", {31'd0, ack}, 32'd0);
    i2c_start();
    write_byte(8'h55, -1, ack);
    chk("rd addr(R) ack", {31'd0, ack}, 32'd0);
    read_byte(rb, 1'b0);
    chk("read byte 0", {24'd0, rb}, 32'h0000_00C3);
    read_byte(rb, 1'b1);
    chk("read byte 1", {24'd0, rb}, 32'h0000_003C);
    wclk(Q);
    chk("sda released after nack", {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    wclk(Q);
    chk("read final pointer", {28'd0, rd_addr}, 32'd3);
    chk("read busy after stop", {31'd0, busy}, 32'd0);

    // Short SCL glitch inside a data byte must not disturb it.
    i2c_start();
    write_byte(8'h54, -1, ack);
    write_byte(8'h06, -1, ack);
    exp_q.push_back('{4'd6, 8'h96});
    write_byte(8'h96, 3, ack);
    chk("glitch data ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    wclk(Q);
    chk("glitch final pointer", {28'd0, rd_addr}, 32'd7);

    // Reset during data bit 4, then the rest of the byte must be ignored.
    i2c_start();
    write_byte(8'h54, -1, ack);
    write_byte(8'h08, -1, ack);
    write_bit(1'b0, 1'b0);
    write_bit(1'b0, 1'b0);
    write_bit(1'b1, 1'b0);
    wclk(Q); sda_m = 1'b1;
    wclk(Q); scl_m = 1'b1;
    wclk(Q);
    rst = 1'b1;
    wclk(1);
    rst = 1'b0;
    chk("rst sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst rd_addr", {28'd0, rd_addr}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    wclk(Q-1); scl_m = 1'b0;
    for (int i = 3; i >= 0; i--) write_bit(i < 2, 1'b0);
    read_bit(ack);
    chk("post-reset ignored ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    wclk(Q);
    chk("post-reset pointer", {28'd0, rd_addr}, 32'd0);

    // Fresh transaction after reset works again.
    i2c_start();
    write_byte(8'h54, -1, ack);
    chk("recover addr ack", {31'd0, ack}, 32'd0);
    write_byte(8'h01, -1, ack);
    exp_q.push_back('{4'd1, 8'h44});
    write_byte(8'h44, -1, ack);
    chk("recover data ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    wclk(Q);
    chk("recover pointer", {28'd0, rd_addr}, 32'd2);
    chk("pending writes", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
